// File: rtl/anim_pkg.sv
// anim_pkg: shared constants and types for the animation tick generator.
//   CLK_HZ     - board clock frequency the divisor constants assume
//   ANIM_CNT_W - default counter/divisor width per channel
//   DIV_1HZ    - terminal count giving a 1 Hz sq (tick at 2 Hz) at CLK_HZ
//   DIV_60HZ   - terminal count for a ~60 Hz tick at CLK_HZ
//   ch_state_e - per-channel one-shot state (armed / done)
package anim_pkg;

  localparam int unsigned CLK_HZ     = 100_000_000;
  localparam int unsigned ANIM_CNT_W = 26;

  localparam logic [ANIM_CNT_W-1:0] DIV_1HZ  = 26'd49_999_999;
  localparam logic [ANIM_CNT_W-1:0] DIV_60HZ = 26'd1_666_666;

  typedef enum logic {
    CH_ARMED = 1'b0,
    CH_DONE  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/anim_tick_gen_if.sv
// anim_tick_gen_if: control/status bundle between game logic and the tick
// generator.
//   en, restart, oneshot [NUM_CH]       - per-channel controls (master drives)
//   div [NUM_CH*CNT_W]                  - per-channel terminal counts, channel i
//                                         at bits [i*CNT_W +: CNT_W]
//   tick, sq, busy [NUM_CH]             - per-channel outputs (slave drives)
interface anim_tick_gen_if
  import anim_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = ANIM_CNT_W
) ();

  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       restart;
  logic [NUM_CH-1:0]       oneshot;
  logic [NUM_CH*CNT_W-1:0] div;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       sq;
  logic [NUM_CH-1:0]       busy;

  modport master (
    output en, restart, oneshot, div,
    input  tick, sq, busy
  );

  modport slave (
    input  en, restart, oneshot, div,
    output tick, sq, busy
  );

endinterface

// File: rtl/anim_tick_ch.sv
// anim_tick_ch: one tick/clock-enable channel.
//   CLK, RST_N - clock, asynchronous active-low reset
//   en         - run enable; counter advances only while high
//   restart    - synchronous clear/re-arm, overrides everything else
//   oneshot    - 0 free-run, 1 one-shot
//   div        - terminal count; period is div+1 enabled cycles
//   tick       - registered one-cycle pulse at terminal count
//   sq         - toggles on every tick
//   busy       - one-shot: enabled and not yet fired; free-run: en
//
// state    | meaning
// CH_ARMED | counting (free-run always sits here)
// CH_DONE  | one-shot has fired; counter parked at 0 until restart or
//          | a switch back to free-run
module anim_tick_ch
  import anim_pkg::*;
#(
  parameter int CNT_W = ANIM_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic             restart,
  input  logic             oneshot,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             sq,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ch_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tick_q, tick_n;
  logic             sq_q, sq_n;
  // Low from reset until the first edge after release, so the first
  // post-reset edge never counts or ticks and busy is forced low
  // asynchronously while reset is asserted.
  logic             live;
  logic             run;
  logic             terminal;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= CH_ARMED;
      cnt    <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
      live   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      tick_q <= tick_n;
      sq_q   <= sq_n;
      live   <= 1'b1;
    end
  end

  assign run = en & live;
  // >= against the live divisor: shrinking div below the current count
  // terminates on the next enabled edge instead of wrapping the counter.
  assign terminal = (cnt >= div);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tick_n  = 1'b0;
    sq_n    = sq_q;

    if (restart) begin
      state_n = CH_ARMED;
      cnt_n   = '0;
      sq_n    = 1'b0;
    end else begin
      if (!oneshot) begin
        state_n = CH_ARMED;
      end
      if (oneshot && (state == CH_DONE)) begin
        cnt_n = '0;
      end else if (run) begin
        if (terminal) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          sq_n   = ~sq_q;
          if (oneshot) begin
            state_n = CH_DONE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign busy = live & en & (~oneshot | (state == CH_ARMED));

endmodule

// File: rtl/anim_tick_gen.sv
// anim_tick_gen: multi-channel programmable tick/clock-enable generator for
// animation timing (ball, paddle, brick flash, score blink).
//   CLK, RST_N - clock, asynchronous active-low reset
//   bus        - slave side of anim_tick_gen_if: per-channel en, restart,
//                oneshot, div in; tick, sq, busy out
// Channels are fully independent; tick is a clock enable, never a clock.
module anim_tick_gen
  import anim_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = ANIM_CNT_W
) (
  input  logic           CLK,
  input  logic           RST_N,
  anim_tick_gen_if.slave bus
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    anim_tick_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .en      (bus.en[i]),
      .restart (bus.restart[i]),
      .oneshot (bus.oneshot[i]),
      .div     (bus.div[i*CNT_W +: CNT_W]),
      .tick    (bus.tick[i]),
      .sq      (bus.sq[i]),
      .busy    (bus.busy[i])
    );
  end

endmodule

// File: tb/tb_anim_tick_gen.sv
// tb_anim_tick_gen: self-checking bench for anim_tick_gen. A vector table
// exercises channel 0 cycle by cycle; hand-written sequences cover pause,
// divisor shrink, one-shot, simultaneous ticks and asynchronous reset.
module tb_anim_tick_gen;

  localparam int NCH = 4;
  localparam int CW  = 26;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  anim_tick_gen_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  anim_tick_gen #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en;
    logic        rs;
    logic        os;
    logic [25:0] dv;
    logic        t;
    logic        s;
    logic        b;
  } vec_t;

  vec_t tv[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int ch, input logic [25:0] v);
    bus.div[ch*CW +: CW] = v;
  endtask

  // Returns number of edges until tick[ch] is seen, or -1 if not within max.
  task automatic wait_tick(input int ch, input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      if (bus.tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  function automatic vec_t mk(input logic en, input logic rs, input logic os,
                              input logic [25:0] dv, input logic t, input logic s,
                              input logic b);
    vec_t v;
    v.en = en; v.rs = rs; v.os = os; v.dv = dv; v.t = t; v.s = s; v.b = b;
    return v;
  endfunction

  int  n;
  int  ticks;
  int  bcount;
  logic flag;
  logic exp_sq;

  initial begin
    //             en  rs  os  div   tick sq busy
    tv[0]  = mk(1, 0, 0, 26'd3, 0, 0, 1);
    tv[1]  = mk(1, 0, 0, 26'd3, 0, 0, 1);
    tv[2]  = mk(1, 0, 0, 26'd3, 0, 0, 1);
    tv[3]  = mk(1, 0, 0, 26'd3, 1, 1, 1);
    tv[4]  = mk(1, 0, 0, 26'd3, 0, 1, 1);
    tv[5]  = mk(1, 1, 0, 26'd3, 0, 0, 1);
    tv[6]  = mk(1, 0, 0, 26'd3, 0, 0, 1);
    tv[7]  = mk(0, 0, 0, 26'd3, 0, 0, 0);
    tv[8]  = mk(0, 0, 0, 26'd3, 0, 0, 0);
    tv[9]  = mk(1, 0, 0, 26'd3, 0, 0, 1);
    tv[10] = mk(1, 0, 0, 26'd3, 0, 0, 1);
    tv[11] = mk(1, 0, 0, 26'd3, 1, 1, 1);
    tv[12] = mk(1, 0, 0, 26'd0, 1, 0, 1);
    tv[13] = mk(1, 0, 0, 26'd0, 1, 1, 1);
    tv[14] = mk(1, 0, 0, 26'd0, 1, 0, 1);
    tv[15] = mk(1, 0, 1, 26'd2, 0, 0, 1);
    tv[16] = mk(1, 0, 1, 26'd2, 0, 0, 1);
    tv[17] = mk(1, 0, 1, 26'd2, 1, 1, 0);
    tv[18] = mk(1, 0, 1, 26'd2, 0, 1, 0);
    tv[19] = mk(0, 0, 1, 26'd2, 0, 1, 0);
    tv[20] = mk(1, 0, 0, 26'd2, 0, 1, 1);
    tv[21] = mk(1, 0, 0, 26'd2, 0, 1, 1);
    tv[22] = mk(1, 0, 0, 26'd2, 1, 0, 1);
    tv[23] = mk(1, 0, 0, 26'd2, 0, 0, 1);
    tv[24] = mk(1, 0, 1, 26'd2, 0, 0, 1);
    tv[25] = mk(1, 0, 1, 26'd2, 1, 1, 0);
    tv[26] = mk(1, 0, 1, 26'd2, 0, 1, 0);

    bus.en      = '0;
    bus.restart = '0;
    bus.oneshot = '0;
    bus.div     = '0;

    // Reset state
    repeat (2) step();
    check("reset tick", 32'(bus.tick), 32'h0);
    check("reset sq",   32'(bus.sq),   32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle tick", 32'(bus.tick), 32'h0);

    // Channel 0 vector table
    for (int i = 0; i < 27; i++) begin
      bus.en[0]      = tv[i].en;
      bus.restart[0] = tv[i].rs;
      bus.oneshot[0] = tv[i].os;
      set_div(0, tv[i].dv);
      step();
      check($sformatf("vec%0d tick", i), 32'(bus.tick), {28'h0, 3'b000, tv[i].t});
      check($sformatf("vec%0d sq", i),   32'(bus.sq),   {28'h0, 3'b000, tv[i].s});
      check($sformatf("vec%0d busy", i), 32'(bus.busy), {28'h0, 3'b000, tv[i].b});
    end
    bus.en = '0; bus.oneshot = '0; bus.restart = '1;
    step();
    bus.restart = '0;

    // Pause/resume on channel 2, div=9
    set_div(2, 26'd9);
    bus.en[2] = 1'b1;
    flag = 1'b0;
    repeat (5) begin
      step();
      if (bus.tick[2]) flag = 1'b1;
    end
    check("pause pre-tick", 32'(flag), 32'h0);
    bus.en[2] = 1'b0;
    flag = 1'b0;
    repeat (20) begin
      step();
      if (bus.tick[2] || bus.sq[2]) flag = 1'b1;
    end
    check("pause hold", 32'(flag), 32'h0);
    check("pause busy", 32'(bus.busy[2]), 32'h0);
    bus.en[2] = 1'b1;
    wait_tick(2, 30, n);
    check("resume edges", 32'(n), 32'd5);
    check("resume sq", 32'(bus.sq[2]), 32'h1);
    wait_tick(2, 30, n);
    check("resume period", 32'(n), 32'd10);
    bus.en[2] = 1'b0;

    // Divisor shrink on channel 3
    set_div(3, 26'd100);
    bus.en[3] = 1'b1;
    repeat (50) step();
    check("shrink no tick", 32'(bus.tick[3]), 32'h0);
    set_div(3, 26'd10);
    wait_tick(3, 5, n);
    check("shrink first", 32'(n), 32'd1);
    wait_tick(3, 20, n);
    check("shrink period", 32'(n), 32'd11);
    bus.en[3] = 1'b0;

    // Simultaneous terminal counts on channels 0 and 1
    bus.restart[1:0] = 2'b11;
    step();
    bus.restart[1:0] = 2'b00;
    set_div(0, 26'd2);
    set_div(1, 26'd2);
    bus.en[1:0] = 2'b11;
    step();
    step();
    check("simul pre", 32'(bus.tick), 32'h0);
    step();
    check("simul tick", 32'(bus.tick), 32'h3);
    bus.en = '0;

    // One-shot on channel 0, div=4, armed twice
    set_div(0, 26'd4);
    bus.oneshot[0] = 1'b1;
    bus.en[0] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      bus.restart[0] = 1'b1;
      step();
      bus.restart[0] = 1'b0;
      bcount = bus.busy[0] ? 1 : 0;
      ticks = 0;
      n = -1;
      for (int k = 1; k <= 60; k++) begin
        step();
        if (bus.tick[0]) begin
          ticks++;
          if (n < 0) n = k;
        end
        if (bus.busy[0]) bcount++;
      end
      check($sformatf("oneshot%0d delay", r), 32'(n), 32'd5);
      check($sformatf("oneshot%0d count", r), 32'(ticks), 32'd1);
      check($sformatf("oneshot%0d busy", r), 32'(bcount), 32'd5);
    end
    bus.oneshot[0] = 1'b0;
    bus.en[0] = 1'b0;

    // Async reset mid-count: ch1 div=0 ticking, ch0 div=3 at count 3
    set_div(0, 26'd3);
    set_div(1, 26'd0);
    bus.restart[1:0] = 2'b11;
    step();
    bus.restart[1:0] = 2'b00;
    bus.en[1:0] = 2'b11;
    exp_sq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_sq = ~exp_sq;
      check($sformatf("div0 tick%0d", k), 32'(bus.tick[1]), 32'h1);
      check($sformatf("div0 sq%0d", k),   32'(bus.sq[1]),   32'(exp_sq));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async tick", 32'(bus.tick), 32'h0);
    check("async sq",   32'(bus.sq),   32'h0);
    check("async busy", 32'(bus.busy), 32'h0);
    repeat (2) step();
    check("in-reset busy", 32'(bus.busy), 32'h0);
    bus.en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    bus.en[0] = 1'b1;
    wait_tick(0, 10, n);
    check("post-reset count", 32'(n), 32'd4);
    bus.en = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/anim_tick_gen.md
Name: anim_tick_gen

Overview:
Multi-channel programmable tick/clock-enable generator for game animation timing: ball step, paddle step, brick flash and score blink.
Each channel divides CLK by a runtime divisor and produces two outputs:
- a one-cycle tick pulse, used as a clock enable, never as a clock;
- a 50%-duty toggle.
Channels run either free-running or one-shot. Sits between the board clock and the game/VGA logic; all consumers stay in the CLK domain.

Parameters:
NUM_CH, 4, number of independent channels
CNT_W, 26, counter/divisor width per channel (26 covers 50_000_000 at 100 MHz)

Ports:
CLK  input  1  system clock; all state on rising edge
RST_N  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel run enable; counter advances only while high
restart  input  NUM_CH  per-channel synchronous clear/re-arm
oneshot  input  NUM_CH  per-channel mode: 0 free-run, 1 one-shot
div  input  NUM_CH*CNT_W  per-channel terminal count; channel i uses bits [i*CNT_W +: CNT_W]; period = div+1 cycles
tick  output  NUM_CH  one-cycle pulse at each terminal count, registered
sq  output  NUM_CH  toggles on every tick; period = 2*(div+1) cycles
busy  output  NUM_CH  one-shot: armed and counting; free-run: equals en

Behaviour:
- Reset (RST_N low, asynchronous): all counters 0, tick 0, sq 0, busy 0, done flags 0. Release is synchronous to CLK, with no tick on the first post-reset edge.
- Terminal condition: counter >= div[i], compared against the live div value. Using >= means a divisor reduced mid-count below the current counter value terminates on the next enabled edge; the counter never runs to 2^CNT_W.
- Free-run, enabled edge:
  - not terminal: counter+1, tick<=0;
  - terminal: counter<=0, tick<=1, sq<=~sq.
  - The first tick after restart/reset is registered on the (div+1)-th enabled edge.
  - div=0: tick high continuously, sq toggles every cycle.
- en low: counter and sq hold, tick<=0. Deasserting en mid-count pauses; reasserting resumes from the held count.
- One-shot (oneshot=1):
  - busy=en & ~done.
  - On terminal: tick<=1, sq toggles, counter<=0, done<=1.
  - While done=1 the counter holds at 0 and tick stays 0, regardless of en.
- restart[i] high: counter<=0, tick<=0, sq<=0, done<=0. It overrides en and the terminal condition in the same cycle.
- Mode change:
  - oneshot sampled every cycle;
  - switching 1->0 clears done at that edge;
  - switching 0->1 mid-count lets the current period finish as a one-shot.
- Channels are fully independent; simultaneous terminal counts on several channels all tick in the same cycle.
- Latency: terminal edge -> tick visible in the following cycle (one register); sq changes in the same cycle as tick.
- Width: counter is CNT_W bits, unsigned compare; no overflow is reachable because of the >= rule.

Decomposition:
- Shared package anim_pkg holds:
  - CLK_HZ=100_000_000;
  - divisor constants DIV_1HZ=49_999_999 and DIV_60HZ=1_666_666, both terminal-count values;
  - ANIM_CNT_W=26.
- Sub-module anim_tick_ch: one channel (counter, done flag, tick/sq registers), with parameter CNT_W.
- anim_tick_gen instantiates anim_tick_ch NUM_CH times with a generate loop and slices the div bus.

Test Plan:
- Reset and free-run: RST_N low then high; en=0001, div[0]=3 -> tick[0] high one cycle every 4 cycles, first on the 4th enabled edge; sq[0] period 8 cycles; other channels tick=0, sq=0.
- div=0: channel 1 en=1, div=0 -> tick[1] constant 1, sq[1] toggles every cycle.
- Pause/resume: div=9, drop en after 5 edges for 20 cycles, then reassert -> next tick exactly 5 enabled edges later; tick 0 and sq held during the pause.
- Divisor shrink: div=100, counter at 50, then div written to 10 -> tick on the very next enabled edge, then every 11 cycles.
- One-shot: oneshot=1, div=4, en held high -> exactly one tick 5 cycles after arm; busy high 5 cycles then low; no further ticks for 50 cycles. Then a restart pulse -> re-arms, a second single tick 5 cycles later.
- Async reset mid-count: assert RST_N low between edges with tick high -> tick, sq, busy drop immediately without a clock edge; counters read 0 after release.
